// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM arbiter.
//   state_e       : sequencer states (IDLE/ISSUE/WAIT_ACK/DONE)
//   M_CPU / M_DMA : master indices (0 = CPU bus, 1 = DMA/disk buffer)
//   ADDR_W/DATA_W : controller-side address and data widths
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DONE
  } state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// One master's stb/we/sel/ack bus into the SDRAM arbiter.
//   stb   : request, held until ack        we    : 1 = write
//   sel   : byte select, [1] = high byte   adr   : word address [21:1]
//   dat_i : write data to the arbiter      dat_o : read data from the arbiter
//   ack   : single-cycle completion        err   : pulses with ack on timeout
// modport master: the requesting side; modport slave: the arbiter side.
interface sdram_arbiter_if;
  import sdram_arb_pkg::*;

  logic              stb;
  logic              we;
  logic [1:0]        sel;
  logic [ADDR_W-2:0] adr;
  logic [DATA_W-1:0] dat_i;
  logic [DATA_W-1:0] dat_o;
  logic              ack;
  logic              err;

  modport master (
    output stb, we, sel, adr, dat_i,
    input  dat_o, ack, err
  );

  modport slave (
    input  stb, we, sel, adr, dat_i,
    output dat_o, ack, err
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way winner select for the SDRAM arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : {m1_stb, m0_stb}
//   update     : strobe in the cycle a grant completes
//   upd_idx    : master that held that grant
//   any / win  : some request present / index of the winning master
// PRIO_MODE 0 alternates between contending masters; PRIO_MODE 1 favours m0
// but hands m1 the grant after MAX_WAIT consecutive m0 wins while m1 waits.
module rr_pick2
  import sdram_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       any,
  output logic       win
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic            prio_q, prio_d;    // master favoured on the next tie
  logic [CntW-1:0] starve_q, starve_d;

  always_comb begin
    any = |req;
    win = M_CPU;
    if (req[M_DMA] && !req[M_CPU]) begin
      win = M_DMA;
    end else if (req[M_DMA] && req[M_CPU]) begin
      if (PRIO_MODE == 0) begin
        win = prio_q;
      end else begin
        win = (starve_q == CntW'(MAX_WAIT)) ? M_DMA : M_CPU;
      end
    end
  end

  always_comb begin
    prio_d   = prio_q;
    starve_d = starve_q;
    if (update) begin
      prio_d = ~upd_idx;
      if (upd_idx == M_CPU && req[M_DMA]) begin
        if (starve_q != CntW'(MAX_WAIT)) starve_d = starve_q + CntW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q   <= M_CPU;
      starve_q <= '0;
    end else begin
      prio_q   <= prio_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter/sequencer in front of the SDRAM controller.
//   clk, rst_n           : controller clock, synchronous active-low reset
//   m0, m1               : master buses (m0 = CPU, m1 = DMA), slave side
//   mem_init_done        : no grants are made until the SDRAM is initialised
//   mem_wr_req/rd_req    : held request to the controller
//   mem_wr_ack/rd_ack    : single-cycle completion from the controller
//   mem_addr/be/wdata    : registered transaction fields, stable while req is high
//   mem_rdata            : read data, valid with mem_rd_ack
//   busy                 : sequencer not idle
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  sdram_arbiter_if.slave    m0,
  sdram_arbiter_if.slave    m1,
  input  logic              mem_init_done,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  input  logic              mem_wr_ack,
  input  logic              mem_rd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              win_q, win_d, we_q, we_d, err_q, err_d;
  logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dat0_q, dat0_d, dat1_q, dat1_d;
  logic [TmoW-1:0]   tmo_q, tmo_d, tmo_inc;

  logic              pick_any, pick_win, ack_match;
  logic              w_we;
  logic [1:0]        w_sel;
  logic [ADDR_W-2:0] w_adr;
  logic [DATA_W-1:0] w_dat;

  rr_pick2 #(
    .PRIO_MODE (PRIO_MODE),
    .MAX_WAIT  (MAX_WAIT)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1.stb, m0.stb}),
    .update  (state_q == DONE),
    .upd_idx (win_q),
    .any     (pick_any),
    .win     (pick_win)
  );

  always_comb begin
    w_we  = m0.we;
    w_sel = m0.sel;
    w_adr = m0.adr;
    w_dat = m0.dat_i;
    if (pick_win == M_DMA) begin
      w_we  = m1.we;
      w_sel = m1.sel;
      w_adr = m1.adr;
      w_dat = m1.dat_i;
    end
  end

  // Acks of the other type are ignored.
  assign ack_match = we_q ? mem_wr_ack : mem_rd_ack;
  assign tmo_inc   = tmo_q + TmoW'(1);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    err_d    = err_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    dat0_d   = dat0_q;
    dat1_d   = dat1_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (mem_init_done && pick_any) begin
          win_d   = pick_win;
          we_d    = w_we;
          addr_d  = {1'b0, w_adr};
          be_d    = w_we ? w_sel : 2'b11;
          wdata_d = w_dat;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wr_req_d = we_q;
        rd_req_d = ~we_q;
        tmo_d    = '0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_match) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          state_d  = DONE;
          if (!we_q) begin
            if (win_q == M_DMA) dat1_d = mem_rdata;
            else                dat0_d = mem_rdata;
          end
        end else if (tmo_inc == TmoW'(TIMEOUT)) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= M_CPU;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      dat0_q   <= '0;
      dat1_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      dat0_q   <= dat0_d;
      dat1_q   <= dat1_d;
      tmo_q    <= tmo_d;
    end
  end

  // Ack is gated by the live stb so a master that gave up gets no pulse.
  assign m0.ack    = (state_q == DONE) && (win_q == M_CPU) && m0.stb;
  assign m1.ack    = (state_q == DONE) && (win_q == M_DMA) && m1.stb;
  assign m0.err    = m0.ack && err_q;
  assign m1.err    = m1.ack && err_q;
  assign m0.dat_o  = dat0_q;
  assign m1.dat_o  = dat1_q;

  assign mem_wr_req = wr_req_q;
  assign mem_rd_req = rd_req_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: dut_a runs round-robin with a short timeout and takes
// directed plus random single-master traffic; dut_b runs fixed priority and is
// only used for the starvation-guard grant order.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int unsigned TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init_done;
  logic        a_wr_req, a_rd_req, a_wr_ack, a_rd_ack, a_busy;
  logic [21:0] a_addr;
  logic [1:0]  a_be;
  logic [15:0] a_wdata, a_rdata;
  logic        b_wr_req, b_rd_req, b_wr_ack, b_rd_ack, b_busy;
  logic [21:0] b_addr;
  logic [1:0]  b_be;
  logic [15:0] b_wdata, b_rdata;

  sdram_arbiter_if a0 ();
  sdram_arbiter_if a1 ();
  sdram_arbiter_if b0 ();
  sdram_arbiter_if b1 ();

  sdram_arbiter #(.PRIO_MODE(0), .MAX_WAIT(4), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1), .mem_init_done(init_done),
    .mem_wr_req(a_wr_req), .mem_rd_req(a_rd_req), .mem_wr_ack(a_wr_ack),
    .mem_rd_ack(a_rd_ack), .mem_addr(a_addr), .mem_be(a_be), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata), .busy(a_busy)
  );

  sdram_arbiter #(.PRIO_MODE(1), .MAX_WAIT(4), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(b0), .m1(b1), .mem_init_done(init_done),
    .mem_wr_req(b_wr_req), .mem_rd_req(b_rd_req), .mem_wr_ack(b_wr_ack),
    .mem_rd_ack(b_rd_ack), .mem_addr(b_addr), .mem_be(b_be), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata), .busy(b_busy)
  );

  logic [1:0] a_ack, a_err;
  assign a_ack = {a1.ack, a0.ack};
  assign a_err = {a1.err, a0.err};

  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_dat [2];
  logic [15:0] mem_m [logic [20:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [20:0] adr);
    if (mem_m.exists(adr)) return mem_m[adr];
    return 16'(adr) ^ 16'hC3C3;
  endfunction

  task automatic mem_wr(input logic [20:0] adr, input logic [1:0] sel, input logic [15:0] dat);
    logic [15:0] old;
    old = mem_rd(adr);
    mem_m[adr] = {sel[1] ? dat[15:8] : old[15:8], sel[0] ? dat[7:0] : old[7:0]};
  endtask

  task automatic drive_a(input bit m, input bit stb, input bit we, input logic [1:0] sel,
                         input logic [20:0] adr, input logic [15:0] dat);
    if (m) begin
      a1.stb = stb; a1.we = we; a1.sel = sel; a1.adr = adr; a1.dat_i = dat;
    end else begin
      a0.stb = stb; a0.we = we; a0.sel = sel; a0.adr = adr; a0.dat_i = dat;
    end
  endtask

  // One transaction on dut_a from an idle start; stb is raised at the current negedge.
  task automatic txn_a(input bit m, input bit we, input logic [1:0] sel, input logic [20:0] adr,
                       input logic [15:0] dat, input int dly, input bit noack, input bit drop);
    int          cyc;
    int          hold;
    logic [15:0] rd;
    drive_a(m, 1'b1, we, sel, adr, dat);
    init_done = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!(a_wr_req || a_rd_req) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_latency", 32'(cyc), 32'd2);
    chk("req_type", 32'({a_wr_req, a_rd_req}), we ? 32'd2 : 32'd1);
    chk("mem_addr", 32'(a_addr), 32'({1'b0, adr}));
    chk("mem_be", 32'(a_be), we ? 32'(sel) : 32'd3);
    if (we) chk("mem_wdata", 32'(a_wdata), 32'(dat));
    if (drop) drive_a(m, 1'b0, we, sel, adr, dat);
    if (noack) begin
      hold = 1;
      while ((a_wr_req || a_rd_req) && hold < 40) begin
        @(negedge clk);
        if (a_wr_req || a_rd_req) hold++;
      end
      chk("timeout_req_cycles", 32'(hold), 32'(TMO));
      chk("timeout_ack", 32'(a_ack), m ? 32'd2 : 32'd1);
      chk("timeout_err", 32'(a_err), m ? 32'd2 : 32'd1);
    end else begin
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        chk("req_held", 32'(we ? a_wr_req : a_rd_req), 32'd1);
        chk("addr_stable", 32'(a_addr), 32'({1'b0, adr}));
        chk("early_ack", 32'(a_ack), 32'd0);
      end
      rd = mem_rd(adr);
      if (we) a_wr_ack = 1'b1;
      else begin
        a_rd_ack = 1'b1;
        a_rdata  = rd;
      end
      @(negedge clk);
      a_wr_ack = 1'b0;
      a_rd_ack = 1'b0;
      a_rdata  = 16'($urandom);
      chk("req_dropped", 32'({a_wr_req, a_rd_req}), 32'd0);
      chk("master_ack", 32'(a_ack), drop ? 32'd0 : (m ? 32'd2 : 32'd1));
      chk("master_err", 32'(a_err), 32'd0);
      if (we) mem_wr(adr, sel, dat);
      else    exp_dat[m] = rd;
      chk("dat_o_m0", 32'(a0.dat_o), 32'(exp_dat[0]));
      chk("dat_o_m1", 32'(a1.dat_o), 32'(exp_dat[1]));
    end
    drive_a(m, 1'b0, we, sel, adr, dat);
    @(negedge clk);
    chk("back_to_idle", 32'({a_busy, a_ack}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit qa[$];
    bit qb[$];
    bit last;
    bit exp_w;
    int cyc;

    rst_n = 1'b0;
    init_done = 1'b1;
    a_wr_ack = 1'b0; a_rd_ack = 1'b0; a_rdata = 16'h0;
    b_wr_ack = 1'b0; b_rd_ack = 1'b0; b_rdata = 16'h0;
    drive_a(1'b1, 1'b0, 1'b0, 2'b00, 21'h0, 16'h0);
    drive_a(1'b0, 1'b1, 1'b0, 2'b11, 21'h00123, 16'h0);
    b0.stb = 0; b0.we = 0; b0.sel = 0; b0.adr = 0; b0.dat_i = 0;
    b1.stb = 0; b1.we = 0; b1.sel = 0; b1.adr = 21'h1; b1.dat_i = 0;
    exp_dat[0] = 16'h0;
    exp_dat[1] = 16'h0;

    // Held in reset with a request pending: everything stays zero.
    repeat (4) @(negedge clk);
    chk("rst_req_busy_a", 32'({a_wr_req, a_rd_req, a_busy}), 32'd0);
    chk("rst_addr_a", 32'(a_addr), 32'd0);
    chk("rst_be_wdata_a", 32'({a_be, a_wdata}), 32'd0);
    chk("rst_ack_err_a", 32'({a_ack, a_err}), 32'd0);
    chk("rst_dat_o_a", {a1.dat_o, a0.dat_o}, 32'd0);
    chk("rst_outs_b", 32'({b_wr_req, b_rd_req, b_busy, b0.ack, b1.ack, b0.err, b1.err}), 32'd0);
    chk("rst_data_b", {b1.dat_o, b0.dat_o}, 32'd0);
    chk("rst_mem_b", 32'({b_addr, b_be}), 32'd0);

    // Released before the SDRAM is ready: stb is ignored.
    init_done = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_req_before_init", 32'({a_wr_req, a_rd_req, a_busy}), 32'd0);
    end

    mem_m[21'h00123] = 16'hBEEF;
    txn_a(1'b0, 1'b0, 2'b11, 21'h00123, 16'h0, 4, 1'b0, 1'b0);
    txn_a(1'b1, 1'b1, 2'b10, 21'h1FFFFF, 16'h5A00, 3, 1'b0, 1'b0);
    txn_a(1'b0, 1'b0, 2'b11, 21'h00055, 16'h0, 0, 1'b1, 1'b0);
    txn_a(1'b1, 1'b0, 2'b11, 21'h1FFFFF, 16'h0, 2, 1'b0, 1'b0);
    txn_a(1'b0, 1'b0, 2'b11, 21'h00077, 16'h0, 3, 1'b0, 1'b1);

    for (int t = 0; t < 30; t++) begin
      txn_a(1'($urandom), 1'($urandom), 2'($urandom), 21'h00100 | 21'($urandom_range(0, 7)),
            16'($urandom), int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    // Reset while waiting for the controller's ack.
    drive_a(1'b0, 1'b1, 1'b0, 2'b11, 21'h00010, 16'h0);
    @(negedge clk);
    cyc = 1;
    while (!a_rd_req && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_req", 32'(a_rd_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_drops_req", 32'({a_wr_req, a_rd_req, a_busy}), 32'd0);
    chk("reset_no_ack", 32'(a_ack), 32'd0);
    drive_a(1'b0, 1'b0, 1'b0, 2'b11, 21'h00010, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both masters held on each DUT; the controller acks every request at once.
    drive_a(1'b0, 1'b1, 1'b0, 2'b11, 21'h00200, 16'h0);
    drive_a(1'b1, 1'b1, 1'b0, 2'b11, 21'h00300, 16'h0);
    b0.stb = 1'b1;
    b1.stb = 1'b1;
    cyc = 0;
    while ((qa.size() < 10 || qb.size() < 10) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (a0.ack) qa.push_back(1'b0);
      if (a1.ack) qa.push_back(1'b1);
      if (b0.ack) qb.push_back(1'b0);
      if (b1.ack) qb.push_back(1'b1);
      a_rd_ack = a_rd_req;
      b_rd_ack = b_rd_req;
      a_rdata  = 16'($urandom);
      b_rdata  = 16'($urandom);
    end
    chk("rr_grant_count", 32'(qa.size() >= 10), 32'd1);
    chk("fp_grant_count", 32'(qb.size() >= 10), 32'd1);
    last = 1'b1;
    for (int i = 0; i < 10 && i < qa.size(); i++) begin
      exp_w = ~last;
      chk($sformatf("rr_grant_%0d", i), 32'(qa[i]), 32'(exp_w));
      last = exp_w;
    end
    for (int i = 0; i < 10 && i < qb.size(); i++) begin
      chk($sformatf("fp_grant_%0d", i), 32'(qb[i]), 32'((i % 5) == 4));
    end

    a0.stb = 1'b0; a1.stb = 1'b0; b0.stb = 1'b0; b1.stb = 1'b0;
    repeat (10) begin
      @(negedge clk);
      a_rd_ack = a_rd_req;
      b_rd_ack = b_rd_req;
    end
    chk("final_idle", 32'({a_busy, b_busy}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the SDRAM controller `sdram_top`.
- Master 0 is the CPU bus; master 1 is a DMA/disk-buffer requester. Both use a stb/we/sel/ack bus.
- Converts each granted transaction into a held `wr_req`/`rd_req` with byte enables, latches read data, and returns a single-cycle ack.
- Blocks all traffic until SDRAM init is done and recovers from a missing ack via a timeout.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between masters; 1 = fixed priority to master 0 with starvation guard.
- MAX_WAIT, 4, fixed-priority mode only: after this many consecutive m0 grants while m1 is pending, m1 gets the next grant.
- TIMEOUT, 1023, cycles in WAIT_ACK before the transaction is aborted with an error.

Ports:
- clk  in  1  controller clock (the 100 MHz clk_p domain)
- rst_n  in  1  synchronous reset, active low
- m0_stb / m1_stb  in  1  transaction request, held until ack
- m0_we / m1_we  in  1  1 = write
- m0_sel / m1_sel  in  2  byte select, active high; [1] = high byte
- m0_adr / m1_adr  in  21  word address [21:1]
- m0_dat_i / m1_dat_i  in  16  write data
- m0_dat_o / m1_dat_o  out  16  read data
- m0_ack / m1_ack  out  1  single-cycle completion pulse
- m0_err / m1_err  out  1  pulses together with ack on timeout
- mem_init_done  in  1  SDRAM initialised
- mem_wr_req / mem_rd_req  out  1  request, held high until the matching ack
- mem_wr_ack / mem_rd_ack  in  1  single-cycle completion from the controller
- mem_addr  out  22  {1'b0, adr[21:1]}
- mem_be  out  2  byte enable, active high
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_rd_ack
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst_n sampled low on a clk edge forces:
  - state = IDLE;
  - all req, ack, err and busy outputs = 0;
  - mem_addr, mem_be and mem_wdata = 0;
  - m*_dat_o = 0;
  - the round-robin pointer selects m0 first;
  - the starvation counter and timeout counter = 0.
- Reset mid-transaction drops the req immediately. No ack is issued.
- FSM states are IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE:
  - If mem_init_done = 0, stay and ignore all stb.
  - Otherwise pick a winner among the asserted stb. Round-robin: the master other than the last winner gets priority. Fixed: m0 wins unless the starvation counter = MAX_WAIT and m1 is pending.
  - Register the winner's we/sel/adr/dat into the mem_* outputs, then go to ISSUE.
- ISSUE (1 cycle):
  - Assert mem_wr_req or mem_rd_req.
  - mem_be = sel for writes and 2'b11 for reads.
  - Clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - Hold req and all mem_* outputs stable.
  - On the matching ack, drop req the same edge; for reads latch mem_rdata into the winner's dat_o; go to DONE.
  - An ack of the wrong type is ignored.
  - When the timeout counter reaches TIMEOUT, drop req, set an internal err flag, and go to DONE.
- DONE (1 cycle):
  - If the winner's stb is still high, pulse the winner's ack, plus err if the flag is set.
  - If stb was dropped mid-transaction, suppress the ack; the SDRAM access still completes.
  - Update the round-robin pointer and the starvation counter: increment on an m0 win with m1 pending, clear on an m1 win or when m1 is idle.
  - Return to IDLE.
- Latency: stb sampled in IDLE at cycle 0 → req high at cycle 2. mem ack at cycle N → master ack at cycle N+1.
- A master still holding stb in the cycle after its ack counts as a new request in the next arbitration.
- dat_o holds its value until the next read completion for that master.
- Both stb asserted simultaneously → resolved per PRIO_MODE; the loser waits with no ack.
- mem_init_done falling while a transaction is in flight: the in-flight transaction finishes and no new grants are made.
- Only one req is ever high at a time.

Decomposition:
- Shared package `sdram_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT_ACK/DONE);
  - master index constants M_CPU = 0, M_DMA = 1;
  - ADDR_W = 22 and DATA_W = 16.
- One natural sub-module: `rr_pick2`, the combinational winner select plus registered pointer and starvation counter.

Test Plan:
- Held in reset: all outputs 0. Release with mem_init_done = 0 and m0_stb = 1 → no req for 20 cycles. Raise mem_init_done → mem_rd_req rises 2 cycles later.
- m0 read at adr 21'h00123; model returns 16'hBEEF on mem_rd_ack at cycle 6 → m0_dat_o = BEEF and a single m0_ack pulse at cycle 7; mem_be = 2'b11.
- m1 write with sel = 2'b10, dat 16'h5A00, adr 21'h1FFFFF → mem_addr = 22'h1FFFFF, mem_be = 2'b10, mem_wr_req held until mem_wr_ack; m1_ack follows 1 cycle later.
- Both stb held continuously, PRIO_MODE = 0 → grants alternate m0, m1, m0, m1. PRIO_MODE = 1, MAX_WAIT = 4 → m0 ×4 then m1.
- No ack from the model with TIMEOUT = 15 → req drops after 15 WAIT_ACK cycles; ack and err pulse together; next request is served normally.
- m0 drops stb in the cycle after ISSUE; mem_rd_ack arrives → no m0_ack and the FSM returns to IDLE. Asserting rst_n = 0 during WAIT_ACK drops req on the next edge.
